// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_mem_pkg;

  // Debug dump sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_t;

  // MEM-stage control bit positions
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  // Default data RAM depth in words
  localparam int RAM_DEPTH_DEFAULT = 2048;

endpackage

// File: rtl/data_mem_arbiter_dump_addr_counter.sv
// Dump word-index counter: loads base/count, steps index and decrements remaining per word.
// Latency: outputs reflect a load or advance one cycle after the request.
// Backpressure: advances only when the parent signals an accepted word.
module dump_addr_counter
  import mips_mem_pkg::*;
#(
  parameter int NB_ADDR = $clog2(RAM_DEPTH_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_ADDR-1:0] i_base,
  input  logic [NB_ADDR:0]   i_count,
  input  logic               i_advance,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_zero,
  output logic               o_more
);

  logic [NB_ADDR:0] remaining;

  // Load on start, otherwise step index (wrapping at RAM depth) and count down
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_addr    <= '0;
      remaining <= '0;
    end else if (i_load) begin
      o_addr    <= i_base;
      remaining <= i_count;
    end else if (i_advance) begin
      o_addr    <= o_addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign o_zero = (remaining == '0);
  assign o_more = (remaining > 1);

endmodule

// File: rtl/data_mem_arbiter.sv
// Data RAM port arbiter: pipe passthrough, or debug dump streaming RAM words out over valid/ready.
// Latency: passthrough is combinational; each dumped word takes at least 3 cycles (issue, capture, send).
// Backpressure: o_dbg_valid/o_dbg_data hold and the address stalls until i_dbg_ready; optional DUMP_CHECKSUM_EN adds o_dbg_checksum.
module data_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int NB_ADDR     = $clog2(RAM_DEPTH_DEFAULT),
  parameter int NB_CTRL_MEM = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LEN-1:0]         i_pipe_address,
  input  logic [LEN-1:0]         i_pipe_write_data,
  input  logic [NB_CTRL_MEM-1:0] i_pipe_ctrl_mem,
  input  logic                   i_pipe_halt,
  output logic [LEN-1:0]         o_mem_address,
  output logic [LEN-1:0]         o_mem_write_data,
  output logic                   o_mem_we,
  output logic                   o_mem_en,
  input  logic [LEN-1:0]         i_mem_read_data,
  input  logic                   i_dbg_start,
  input  logic [NB_ADDR-1:0]     i_dbg_base,
  input  logic [NB_ADDR:0]       i_dbg_count,
  output logic [LEN-1:0]         o_dbg_data,
  output logic                   o_dbg_valid,
  input  logic                   i_dbg_ready,
  output logic                   o_dbg_busy,
  output logic                   o_dbg_done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [LEN-1:0]         o_dbg_checksum
`endif
);

  dump_state_t        state;
  logic               pending;
  logic               start_accept;
  logic               word_accept;
  logic [NB_ADDR-1:0] dump_addr;
  logic               cnt_zero;
  logic               cnt_more;
  logic               unused_branch;

  // Branch bit travels with MEM control but has no meaning at the RAM port
  assign unused_branch = i_pipe_ctrl_mem[CTRL_BRANCH];

  assign start_accept = i_dbg_start && (state == ST_IDLE) && !pending;
  assign word_accept  = (state == ST_SEND) && o_dbg_valid && i_dbg_ready;
  assign o_dbg_busy   = pending || (state != ST_IDLE);

  dump_addr_counter #(
    .NB_ADDR (NB_ADDR)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (start_accept),
    .i_base    (i_dbg_base),
    .i_count   (i_dbg_count),
    .i_advance (word_accept),
    .o_addr    (dump_addr),
    .o_zero    (cnt_zero),
    .o_more    (cnt_more)
  );

  // Dump sequencer with registered debug outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      o_dbg_data  <= '0;
      o_dbg_valid <= 1'b0;
      o_dbg_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_accept) begin
            pending <= 1'b1;
          end else if (pending && i_pipe_halt) begin
            pending <= 1'b0;
            if (cnt_zero) begin
              state      <= ST_DONE;
              o_dbg_done <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Read is only launched while the pipeline stays frozen
          if (i_pipe_halt) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          o_dbg_data  <= i_mem_read_data;
          o_dbg_valid <= 1'b1;
          state       <= ST_SEND;
        end
        ST_SEND: begin
          if (i_dbg_ready) begin
            o_dbg_valid <= 1'b0;
            if (cnt_more) begin
              state <= ST_ISSUE;
            end else begin
              state      <= ST_DONE;
              o_dbg_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          o_dbg_done <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM port mux: pipe owns it in IDLE, sequencer reads (never writes) otherwise
  always_comb begin
    o_mem_address    = {{(LEN-NB_ADDR-2){1'b0}}, dump_addr, 2'b00};
    o_mem_write_data = i_pipe_write_data;
    o_mem_we         = 1'b0;
    o_mem_en         = (state == ST_ISSUE) && i_pipe_halt;
    if (state == ST_IDLE) begin
      o_mem_address = i_pipe_address;
      o_mem_we      = i_pipe_ctrl_mem[CTRL_MEMWRITE];
      o_mem_en      = i_pipe_ctrl_mem[CTRL_MEMREAD];
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running sum of accepted words, cleared by the start that opens a dump
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dbg_checksum <= '0;
    end else if (start_accept) begin
      o_dbg_checksum <= '0;
    end else if (word_accept) begin
      o_dbg_checksum <= o_dbg_checksum + o_dbg_data;
    end
  end
`endif

endmodule
